// File: rtl/fwrisc_trace_fifo_if.sv
// fwrisc_trace_fifo_if: merged trace record stream from the FIFO head to a sink
interface fwrisc_trace_fifo_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  out_flags;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic [31:0] out_mem_addr;
  logic [3:0]  out_mem_rmask;
  logic [3:0]  out_mem_wmask;
  logic [31:0] out_mem_data;
  modport master (
    output out_valid, out_pc, out_instr, out_flags, out_rd_addr, out_rd_wdata,
           out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_data,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_pc, out_instr, out_flags, out_rd_addr, out_rd_wdata,
           out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_data,
    output out_ready
  );
endinterface

// File: rtl/fwrisc_trace_fifo.sv
// fwrisc_trace_fifo: merges retirements with their side effects and queues them with drop accounting
module fwrisc_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic                   ivalid,
  input  logic                   trap,
  input  logic                   tret,
  input  logic [4:0]             rd_waddr,
  input  logic [31:0]            rd_wdata,
  input  logic                   rd_write,
  input  logic [31:0]            maddr,
  input  logic [31:0]            mdata,
  input  logic [3:0]             mstrb,
  input  logic                   mwrite,
  input  logic                   mvalid,
  fwrisc_trace_fifo_if.master    tr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_data;
  } side_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  flags;
    side_t       side;
  } rec_t;
  side_t         acc;
  side_t         side_nxt;
  rec_t          rec;
  rec_t          head;
  rec_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;
  logic          drop;
  // fold this cycle's strobes over the latched ones; a new mem access replaces the whole mem side effect
  always_comb begin
    side_nxt = acc;
    if (rd_write) begin
      side_nxt.rd_addr  = rd_waddr;
      side_nxt.rd_wdata = rd_wdata;
    end
    if (mvalid) begin
      side_nxt.mem_addr  = maddr;
      side_nxt.mem_data  = mdata;
      side_nxt.mem_wmask = mwrite ? mstrb : 4'h0;
      side_nxt.mem_rmask = mwrite ? 4'h0 : mstrb;
    end
    rec = {pc, instr, tret, trap, side_nxt};
  end
  // accumulator is consumed (zeroed) by every retirement, captured or not
  always_ff @(posedge clock)
    if (!reset || clr || ivalid) acc <= '0;
    else acc <= side_nxt;
  assign tr.out_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign push = ivalid && en && !clr;
  assign pop  = tr.out_valid && tr.out_ready && !clr;
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;
  // storage needs no reset: count alone decides what is visible
  always_ff @(posedge clock)
    if (wr) mem[wp] <= rec;
  // pointers wrap naturally at DEPTH; occupancy kept as its own counter
  always_ff @(posedge clock)
    if (!reset || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  // sticky overflow and saturating drop counter
  always_ff @(posedge clock)
    if (!reset || clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (~&drop_cnt) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  assign head = tr.out_valid ? mem[rp] : '0;
  assign {tr.out_pc, tr.out_instr, tr.out_flags, tr.out_rd_addr, tr.out_rd_wdata,
          tr.out_mem_addr, tr.out_mem_rmask, tr.out_mem_wmask, tr.out_mem_data} = head;
endmodule
